// File: rtl/cvt_pkg.sv
// Shared definitions for the CVT token issuer: token layout,
// branch-event FIFO entry and issuer FSM states.
package cvt_pkg;

    localparam int TID_W = 10;
    localparam int BB_W  = 5;
    localparam int TOK_W = 24;

    localparam int TOK_CFG_BIT   = 0;
    localparam int TOK_CTRL_BIT  = 1;
    localparam int TOK_VALID_BIT = 2;
    localparam int TOK_BB1_LSB   = 3;
    localparam int TOK_BB2_LSB   = 8;
    localparam int TOK_BUF_LSB   = 13;
    localparam int TOK_FORCE_BIT = 23;

    typedef struct packed {
        logic             force_w;
        logic [TID_W-1:0] token_buffer;
        logic [BB_W-1:0]  bb_target_2;
        logic [BB_W-1:0]  bb_target_1;
        logic             token_valid;
        logic             ctrl;
        logic             cfg;
    } cvt_token_t;

    typedef struct packed {
        logic             force_w;
        logic [TID_W-1:0] tid;
        logic [BB_W-1:0]  t2;
        logic [BB_W-1:0]  t1;
    } br_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } issuer_state_e;

    function automatic logic [TOK_W-1:0] mk_cfg_token(
        input logic [TID_W-1:0] id
    );
        logic [TOK_W-1:0] t;
        t = '0;
        t[TOK_CFG_BIT]              = 1'b1;
        t[TOK_VALID_BIT]            = 1'b1;
        t[TOK_BUF_LSB +: TID_W]     = id;
        return t;
    endfunction

    function automatic logic [TOK_W-1:0] mk_br_token(
        input br_entry_t e
    );
        logic [TOK_W-1:0] t;
        t = '0;
        t[TOK_CTRL_BIT]             = 1'b1;
        t[TOK_VALID_BIT]            = 1'b1;
        t[TOK_BB1_LSB +: BB_W]      = e.t1;
        t[TOK_BB2_LSB +: BB_W]      = e.t2;
        t[TOK_BUF_LSB +: TID_W]     = e.tid;
        t[TOK_FORCE_BIT]            = e.force_w;
        return t;
    endfunction

endpackage

// File: rtl/cvt_issue_fifo.sv
// Synchronous branch-event FIFO; registered read path, so a push
// into an empty FIFO is first visible at the head the next cycle.
module cvt_issue_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cvt_token_issuer.sv
// CVT input-token issuer: config tokens, then queued branch tokens.
// Optional counters enabled by defining CVT_ISSUER_STATS_EN.
module cvt_token_issuer #(
    parameter int TID_W      = 10,
    parameter int BB_W       = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_id_valid,
    output logic             cfg_id_ready,
    input  logic [TID_W-1:0] cfg_id,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [BB_W-1:0]  br_target_1,
    input  logic [BB_W-1:0]  br_target_2,
    input  logic [TID_W-1:0] br_tid,
    input  logic             br_force,
    input  logic             cvt_stall,
    input  logic             threads_terminated,
    output logic [23:0]      cvt_token,
    output logic             issuer_done
`ifdef CVT_ISSUER_STATS_EN
    ,
    output logic [15:0]      stat_tokens,
    output logic [15:0]      stat_stall_cycles
`endif
);

    import cvt_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    issuer_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cvt_token_t       tok_q, tok_d;
    br_entry_t        push_e, head_e;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_cnt;

    assign push_e = '{
        force_w: br_force,
        tid:     br_tid,
        t2:      br_target_2,
        t1:      br_target_1
    };

    cvt_issue_fifo #(
        .W     ($bits(br_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_e),
        .pop_i   (pop),
        .dout_o  (head_e),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tok_d        = '0;
        cfg_id_ready = 1'b0;
        br_ready     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    cnt_d   = cfg_count;
                    state_d = (cfg_count == '0) ? ST_RUN : ST_CFG;
                end
            end
            ST_CFG: begin
                cfg_id_ready = !cvt_stall;
                if (cfg_id_valid && !cvt_stall) begin
                    tok_d = mk_cfg_token(cfg_id);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                br_ready = !fifo_full;
                push     = br_valid && !fifo_full;
                pop      = !fifo_empty && !cvt_stall;
                if (pop) begin
                    tok_d = mk_br_token(head_e);
                end
                if (threads_terminated) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pop = !fifo_empty && !cvt_stall;
                if (pop) begin
                    tok_d = mk_br_token(head_e);
                end
                // Last token already left the FIFO a cycle earlier.
                if (fifo_cnt == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cvt_token   = tok_q;
    assign issuer_done = (state_q == ST_DONE);

`ifdef CVT_ISSUER_STATS_EN
    logic [15:0] stat_tok_q;
    logic [15:0] stat_stl_q;
    logic        pending;

    assign pending = (state_q == ST_CFG) ||
                     (((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                      !fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tok_q <= '0;
            stat_stl_q <= '0;
        end else if (state_q != ST_DONE) begin
            if (tok_d.token_valid && (stat_tok_q != 16'hFFFF)) begin
                stat_tok_q <= stat_tok_q + 16'd1;
            end
            if (cvt_stall && pending && (stat_stl_q != 16'hFFFF)) begin
                stat_stl_q <= stat_stl_q + 16'd1;
            end
        end
    end

    assign stat_tokens       = stat_tok_q;
    assign stat_stall_cycles = stat_stl_q;
`endif

endmodule

// File: tb/tb_cvt_token_issuer.sv
// Self-checking bench for cvt_token_issuer against a queue-based
// reference model of the token stream.
module tb_cvt_token_issuer;

    localparam int P_IDLE  = 0;
    localparam int P_CFG   = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [3:0]  cfg_count;
    logic        cfg_id_valid;
    logic        cfg_id_ready;
    logic [9:0]  cfg_id;
    logic        br_valid;
    logic        br_ready;
    logic [4:0]  br_target_1;
    logic [4:0]  br_target_2;
    logic [9:0]  br_tid;
    logic        br_force;
    logic        cvt_stall;
    logic        threads_terminated;
    logic [23:0] cvt_token;
    logic        issuer_done;

    int checks   = 0;
    int failures = 0;

    int          ph = P_IDLE;
    int          left = 0;
    logic [23:0] mq[$];

    always #5 clk = ~clk;

    cvt_token_issuer dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start          (cfg_start),
        .cfg_count          (cfg_count),
        .cfg_id_valid       (cfg_id_valid),
        .cfg_id_ready       (cfg_id_ready),
        .cfg_id             (cfg_id),
        .br_valid           (br_valid),
        .br_ready           (br_ready),
        .br_target_1        (br_target_1),
        .br_target_2        (br_target_2),
        .br_tid             (br_tid),
        .br_force           (br_force),
        .cvt_stall          (cvt_stall),
        .threads_terminated (threads_terminated),
        .cvt_token          (cvt_token),
        .issuer_done        (issuer_done)
    );

    function automatic logic [23:0] cfg_tok(input logic [9:0] id);
        return (24'(id) << 13) + 24'h000005;
    endfunction

    function automatic logic [23:0] br_tok(
        input logic [4:0] t1, input logic [4:0] t2,
        input logic [9:0] tid, input logic f
    );
        return (24'(f) << 23) + (24'(tid) << 13) + (24'(t2) << 8) +
               (24'(t1) << 3) + 24'h000006;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_br();
        br_target_1 = 5'($urandom);
        br_target_2 = 5'($urandom);
        br_tid      = 10'($urandom);
        br_force    = 1'($urandom);
    endtask

    // Check handshake outputs, advance the model one cycle, then
    // check the registered token and done flag after the edge.
    task automatic tick();
        logic [23:0] nt;
        int n;
        #2;
        chk("cfg_id_ready", 24'(cfg_id_ready),
            24'((ph == P_CFG) && !cvt_stall));
        chk("br_ready", 24'(br_ready),
            24'((ph == P_RUN) && (mq.size() < DEPTH)));
        nt = '0;
        if (rst) begin
            ph = P_IDLE;
            left = 0;
            mq.delete();
        end else begin
            case (ph)
                P_IDLE, P_DONE: begin
                    if (cfg_start) begin
                        left = int'(cfg_count);
                        ph = (left == 0) ? P_RUN : P_CFG;
                    end
                end
                P_CFG: begin
                    if (cfg_id_valid && !cvt_stall) begin
                        nt = cfg_tok(cfg_id);
                        left--;
                        if (left == 0) ph = P_RUN;
                    end
                end
                P_RUN: begin
                    n = mq.size();
                    if (n > 0 && !cvt_stall) nt = mq.pop_front();
                    if (br_valid && n < DEPTH)
                        mq.push_back(br_tok(br_target_1, br_target_2,
                                            br_tid, br_force));
                    if (threads_terminated) ph = P_DRAIN;
                end
                P_DRAIN: begin
                    if (mq.size() == 0) ph = P_DONE;
                    else if (!cvt_stall) nt = mq.pop_front();
                end
                default: ph = P_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        chk("cvt_token", cvt_token, nt);
        chk("issuer_done", 24'(issuer_done), 24'(ph == P_DONE));
    endtask

    initial begin
        logic [9:0] ids [3];
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_count = '0;
        cfg_id_valid = 1'b0;
        cfg_id = '0;
        br_valid = 1'b0;
        br_target_1 = '0;
        br_target_2 = '0;
        br_tid = '0;
        br_force = 1'b0;
        cvt_stall = 1'b0;
        threads_terminated = 1'b0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_token", cvt_token, 24'h0);
        rst = 1'b0;
        tick();

        // Three config tokens back to back
        cfg_start = 1'b1;
        cfg_count = 4'd3;
        tick();
        cfg_start = 1'b0;
        ids[0] = 10'h010;
        ids[1] = 10'h020;
        ids[2] = 10'h030;
        for (int i = 0; i < 3; i++) begin
            cfg_id_valid = 1'b1;
            cfg_id = ids[i];
            tick();
        end
        cfg_id_valid = 1'b0;
        chk("cfg_last_token", cvt_token, 24'h060005);

        // Single branch, latency two from handshake
        br_valid = 1'b1;
        br_target_1 = 5'd3;
        br_target_2 = 5'd7;
        br_tid = 10'h3FF;
        br_force = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        chk("branch_token", cvt_token, 24'hFFE71E);
        tick();

        // Fill under stall, then release
        cvt_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            br_valid = 1'b1;
            rand_br();
            tick();
        end
        chk("full_br_ready", 24'(br_ready), 24'h0);
        br_valid = 1'b0;
        cvt_stall = 1'b0;
        repeat (6) tick();

        // Push and pop together at occupancy 2
        cvt_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            br_valid = 1'b1;
            rand_br();
            tick();
        end
        cvt_stall = 1'b0;
        rand_br();
        tick();
        br_valid = 1'b0;
        repeat (4) tick();

        // Random RUN traffic; cfg_start here must be ignored
        for (int i = 0; i < 300; i++) begin
            cvt_stall = ($urandom_range(3) == 0);
            br_valid = 1'($urandom);
            rand_br();
            cfg_start = ($urandom_range(15) == 0);
            cfg_count = 4'($urandom);
            tick();
        end
        cfg_start = 1'b0;
        cvt_stall = 1'b0;
        br_valid = 1'b0;
        repeat (6) tick();

        // Terminate with entries queued, event in the same cycle kept
        cvt_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            br_valid = 1'b1;
            rand_br();
            tick();
        end
        threads_terminated = 1'b1;
        rand_br();
        tick();
        threads_terminated = 1'b0;
        cvt_stall = 1'b0;
        rand_br();
        for (int i = 0; i < 12 && ph != P_DONE; i++) tick();
        br_valid = 1'b0;
        tick();
        chk("drain_done", 24'(issuer_done), 24'h1);
        chk("drain_idle_token", cvt_token, 24'h0);

        // Reset in the middle of a config phase
        cfg_start = 1'b1;
        cfg_count = 4'd3;
        tick();
        cfg_start = 1'b0;
        cfg_id_valid = 1'b1;
        cfg_id = 10'($urandom);
        tick();
        cfg_id_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midcfg_reset_token", cvt_token, 24'h0);
        chk("midcfg_reset_done", 24'(issuer_done), 24'h0);
        rst = 1'b0;
        tick();
        cfg_start = 1'b1;
        cfg_count = 4'd3;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 40 && ph == P_CFG; i++) begin
            cfg_id_valid = 1'($urandom);
            cfg_id = 10'($urandom);
            cvt_stall = ($urandom_range(3) == 0);
            threads_terminated = 1'($urandom);
            br_valid = 1'($urandom);
            tick();
        end
        chk("restart_reached_run", 24'(ph), 24'(P_RUN));
        cfg_id_valid = 1'b0;
        cvt_stall = 1'b0;
        threads_terminated = 1'b0;
        br_valid = 1'b0;
        tick();

        // Terminate empty, then restart with a zero count
        threads_terminated = 1'b1;
        tick();
        threads_terminated = 1'b0;
        repeat (3) tick();
        cfg_start = 1'b1;
        cfg_count = 4'd0;
        tick();
        cfg_start = 1'b0;
        chk("zero_count_br_ready", 24'(br_ready), 24'h1);
        br_valid = 1'b1;
        rand_br();
        tick();
        br_valid = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
